fetch_buffer: RTL

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer_if.sv | 24 ++
 rtl/fetch_buffer.sv | 110 +++++++++++
 2 files changed

// File: rtl/fetch_buffer_if.sv
// Fetch buffer bus bundle: consumer-side instruction handshake, cache read port and redirect.
// The master modport belongs to the fetch buffer itself.
interface fetch_buffer_if;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        instr_ready_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        cache_read_o;
  logic [31:0] cache_addr_o;
  logic [31:0] cache_data_i;
  logic        cache_valid_i;

  modport master (
    input  branch_i, branch_addr_i, instr_ready_i, cache_data_i, cache_valid_i,
    output instr_valid_o, instr_o, instr_pc_o, cache_read_o, cache_addr_o
  );

  modport slave (
    output branch_i, branch_addr_i, instr_ready_i, cache_data_i, cache_valid_i,
    input  instr_valid_o, instr_o, instr_pc_o, cache_read_o, cache_addr_o
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: sequential cache reads into a DEPTH-entry {pc, instr} FIFO,
// with branch redirect that drains an in-flight miss at its original address.
module fetch_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input logic            clk,
  input logic            rstn_i,
  fetch_buffer_if.master fb
);
  localparam int unsigned   AW   = $clog2(DEPTH);
  localparam int unsigned   CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fb_entry_t;

  typedef enum logic {FETCH, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     drain_addr_q, drain_addr_d;
  logic            pend_q, pend_d;
  logic [CW-1:0]   count_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  fb_entry_t       mem_q [DEPTH];
  fb_entry_t       head;
  logic            rd_req, push, pop, not_empty;
  logic [31:0]     tgt;
  logic            unused_baddr_lo;

  assign tgt             = {fb.branch_addr_i[31:2], 2'b00};
  assign unused_baddr_lo = ^fb.branch_addr_i[1:0];
  assign not_empty       = (count_q != '0);
  assign pop             = not_empty & fb.instr_ready_i & ~fb.branch_i;
  assign head            = mem_q[rd_ptr_q];

  // Next-state / request logic; fetch_pc only advances on a real push.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    pend_d       = 1'b0;
    rd_req       = 1'b0;
    push         = 1'b0;
    case (state_q)
      FETCH: begin
        rd_req = (count_q < FULL) | pend_q;
        if (fb.branch_i) begin
          fetch_pc_d = tgt;
          if (rd_req & ~fb.cache_valid_i) begin
            state_d      = DRAIN;
            drain_addr_d = fetch_pc_q;
          end
        end else if (rd_req & fb.cache_valid_i) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end else begin
          pend_d = rd_req;
        end
      end
      DRAIN: begin
        // The cache still owes us the old line; hold it until it returns, then drop it.
        rd_req = 1'b1;
        if (fb.branch_i)      fetch_pc_d = tgt;
        if (fb.cache_valid_i) state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= FETCH;
      fetch_pc_q   <= BOOT_ADDR;
      drain_addr_q <= BOOT_ADDR;
      pend_q       <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      pend_q       <= pend_d;
      if (fb.branch_i) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        count_q  <= count_q + CW'(push) - CW'(pop);
        wr_ptr_q <= wr_ptr_q + AW'(push);
        rd_ptr_q <= rd_ptr_q + AW'(pop);
      end
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: fetch_pc_q, instr: fb.cache_data_i};
  end

  assign fb.cache_read_o  = rstn_i & rd_req;
  assign fb.cache_addr_o  = !rstn_i ? 32'h0 : (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;
  assign fb.instr_valid_o = not_empty;
  assign fb.instr_o       = not_empty ? head.instr : 32'h0;
  assign fb.instr_pc_o    = not_empty ? head.pc    : 32'h0;
endmodule
